// File: rtl/lemming_world.sv
// Closed-loop environment for the lemming walker: turns walker status into
// ground/bump inputs while tracking position on a 1-D terrain of diggable columns.
module lemming_world #(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 8,
  parameter int               START_X    = 3,
  parameter logic [WIDTH-1:0] HOLE_MASK  = 8'b0100_0000,
  parameter int               MOVE_DIV   = 2,
  parameter int               DIG_CYCLES = 3,
  localparam int              XW         = $clog2(WIDTH),
  localparam int              YW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          walk_left,
  input  logic          walk_right,
  input  logic          aaah,
  input  logic          digging,
  output logic          ground,
  output logic          bump_left,
  output logic          bump_right,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic          abyss,
  output logic          proto_err
);

  localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int DW = (DIG_CYCLES > 1) ? $clog2(DIG_CYCLES) : 1;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [YW-1:0] floor_q [WIDTH];
  logic [MW-1:0] move_cnt;
  logic [DW-1:0] dig_cnt;

  logic [YW-1:0] fl_here;
  logic [YW-1:0] fl_left;
  logic [YW-1:0] fl_right;
  logic          at_left_edge;
  logic          at_right_edge;

  always_comb begin
    at_left_edge  = (x == '0);
    at_right_edge = (x == XW'(WIDTH - 1));
    fl_here       = floor_q[x];
    fl_left       = '0;
    fl_right      = '0;
    if (!at_left_edge)  fl_left  = floor_q[x - 1'b1];
    if (!at_right_edge) fl_right = floor_q[x + 1'b1];
    ground     = (fl_here == y) && (fl_here != YW'(DEPTH));
    bump_left  = at_left_edge  || (fl_left  < y);
    bump_right = at_right_edge || (fl_right < y);
    abyss      = (y == YW'(DEPTH));
    pos_x      = x;
    pos_y      = y;
  end

  // Exactly one action class acts per cycle, in priority order; counters of
  // actions that did not run this cycle are cleared so partial progress never
  // survives an interruption.
  always_ff @(posedge clk) begin
    if (reset) begin
      x         <= XW'(START_X);
      y         <= '0;
      move_cnt  <= '0;
      dig_cnt   <= '0;
      proto_err <= 1'b0;
      for (int c = 0; c < WIDTH; c++)
        floor_q[c] <= HOLE_MASK[c] ? YW'(DEPTH) : '0;
    end else if (walk_left && walk_right) begin
      proto_err <= 1'b1;
      move_cnt  <= '0;
      dig_cnt   <= '0;
    end else if (walk_left || walk_right) begin
      dig_cnt <= '0;
      if (move_cnt == MW'(MOVE_DIV - 1)) begin
        move_cnt <= '0;
        if (walk_left && !bump_left)
          x <= x - 1'b1;
        else if (walk_right && !bump_right)
          x <= x + 1'b1;
      end else begin
        move_cnt <= move_cnt + 1'b1;
      end
    end else if (aaah) begin
      move_cnt <= '0;
      dig_cnt  <= '0;
      if (!ground && (y != YW'(DEPTH)))
        y <= y + 1'b1;
    end else if (digging && ground) begin
      move_cnt <= '0;
      if (dig_cnt == DW'(DIG_CYCLES - 1)) begin
        dig_cnt    <= '0;
        floor_q[x] <= fl_here + 1'b1;
      end else begin
        dig_cnt <= dig_cnt + 1'b1;
      end
    end else begin
      move_cnt <= '0;
      dig_cnt  <= '0;
    end
  end

endmodule
